// File: rtl/ctl_status_pkg.sv
// ctl_status_pkg: shared BRAM address map, control-register bit positions and writer FSM states.
package ctl_status_pkg;
    typedef enum logic [2:0] {IDLE, RD_CTL, RD_WAIT, RD_LATCH, WR_INFO, WR_SYNC, WR_VER} state_t;
    localparam logic [8:0] ADDR_CTL_REG   = 9'h000;
    localparam logic [8:0] ADDR_FPGA_INFO = 9'h001;
    localparam logic [8:0] ADDR_SYNC_CNT  = 9'h002;
    localparam logic [8:0] ADDR_VERSION   = 9'h03F;
    localparam int CTL_FORCE_FAN_BIT = 4;
endpackage

// File: rtl/ctl_status_writer_thermo_debounce.sv
// thermo_debounce: output follows the input only after DEBOUNCE consecutive samples at a new level.
module thermo_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    localparam int CW = $clog2(DEBOUNCE) + 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE - 1)) begin
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ctl_status_writer.sv
// ctl_status_writer: periodically reads the control word and writes info/sync-count/version status words to BRAM.
// Optional THERMO debouncing is enabled with `define THERMO_DEBOUNCE_EN.
module ctl_status_writer
    import ctl_status_pkg::*;
#(
    parameter int          INTERVAL = 2048,
    parameter logic [15:0] VERSION  = 16'h0082,
    parameter int          DEBOUNCE = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        THERMO,
    input  logic        SYNC_SET,
    output logic        BRAM_EN,
    output logic        BRAM_WE,
    output logic [8:0]  BRAM_ADDR,
    output logic [15:0] BRAM_DIN,
    input  logic [15:0] BRAM_DOUT,
    output logic        FAN_ACTIVE,
    output logic        SEQ_DONE
);
    localparam int CW = $clog2(INTERVAL);

    if (INTERVAL < 8 || DEBOUNCE < 1) begin : g_param_check
        $error("ctl_status_writer: INTERVAL must be >= 8 and DEBOUNCE >= 1");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   sync_cnt;
    logic          force_fan;
    logic          thermo_q;
    logic          tick;
    logic          fan_bit;
    logic          force_next;
    logic          unused_dout;

    assign tick        = cnt == CW'(INTERVAL - 1);
    assign fan_bit     = BRAM_DOUT[CTL_FORCE_FAN_BIT];
    assign force_next  = (state == RD_LATCH) ? fan_bit : force_fan;
    assign unused_dout = ^(BRAM_DOUT & ~(16'd1 << CTL_FORCE_FAN_BIT));

`ifdef THERMO_DEBOUNCE_EN
    thermo_debounce #(.DEBOUNCE(DEBOUNCE)) u_thermo_debounce (
        .clk (CLK),
        .rst (RST),
        .d   (THERMO),
        .q   (thermo_q)
    );
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) thermo_q <= 1'b0;
        else     thermo_q <= THERMO;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            sync_cnt   <= '0;
            force_fan  <= 1'b0;
            BRAM_EN    <= 1'b0;
            BRAM_WE    <= 1'b0;
            BRAM_ADDR  <= '0;
            BRAM_DIN   <= '0;
            FAN_ACTIVE <= 1'b0;
            SEQ_DONE   <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            sync_cnt   <= sync_cnt + 16'(SYNC_SET);
            FAN_ACTIVE <= thermo_q | force_next;
            BRAM_EN    <= 1'b0;
            BRAM_WE    <= 1'b0;
            SEQ_DONE   <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    state     <= RD_CTL;
                    BRAM_EN   <= 1'b1;
                    BRAM_ADDR <= ADDR_CTL_REG;
                end
                RD_CTL:  state <= RD_WAIT;
                RD_WAIT: state <= RD_LATCH;
                RD_LATCH: begin
                    // read data arrives this cycle, so the info word uses it directly
                    state     <= WR_INFO;
                    force_fan <= fan_bit;
                    BRAM_EN   <= 1'b1;
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= ADDR_FPGA_INFO;
                    BRAM_DIN  <= {14'b0, thermo_q | fan_bit, thermo_q};
                end
                WR_INFO: begin
                    // value the counter holds at the start of the WR_SYNC cycle
                    state     <= WR_SYNC;
                    BRAM_EN   <= 1'b1;
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= ADDR_SYNC_CNT;
                    BRAM_DIN  <= sync_cnt + 16'(SYNC_SET);
                end
                WR_SYNC: begin
                    state     <= WR_VER;
                    BRAM_EN   <= 1'b1;
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= ADDR_VERSION;
                    BRAM_DIN  <= VERSION;
                end
                WR_VER: begin
                    state    <= IDLE;
                    SEQ_DONE <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ctl_status_writer.md
Name: ctl_status_writer

Overview:
- FPGA-side writer into the controller BRAM region. The CPU reads this region back as the status/readback words.
- It is the counterpart of the config path, where the CPU writes and the controller reads. Here the FPGA writes and the CPU reads.
- Every INTERVAL cycles the block runs one fixed sequence:
  - reads the control register to obtain the force-fan request;
  - writes the FPGA info word;
  - writes the sync-event counter;
  - writes the firmware version.
- Sits beside controller on the same BRAM controller port; the address map is shared with controller.

Parameters:
INTERVAL, 2048, cycles between sequence starts; must be >= 8
VERSION, 16'h0082, firmware version word written to ADDR_VERSION
DEBOUNCE, 16, consecutive stable samples required for THERMO (used only with THERMO_DEBOUNCE_EN)

Ports:
CLK  input  1  system clock (20.48 MHz domain)
RST  input  1  asynchronous reset, active-high
THERMO  input  1  raw over-temperature flag, synchronous to CLK
SYNC_SET  input  1  one-cycle pulse per EtherCAT sync event
BRAM_EN  output  1  BRAM port enable
BRAM_WE  output  1  BRAM write enable
BRAM_ADDR  output  9  BRAM word address
BRAM_DIN  output  16  write data
BRAM_DOUT  input  16  read data; valid 2 cycles after the EN=1, WE=0 cycle
FAN_ACTIVE  output  1  registered thermo_q OR force_fan
SEQ_DONE  output  1  one-cycle pulse after the final write of a sequence

Behaviour:
- Reset values (all registers async-clear on RST=1):
  - BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DIN=0;
  - FAN_ACTIVE=0, SEQ_DONE=0;
  - state=IDLE, interval counter=0, sync_cnt=0, force_fan=0.
- Interval counter: runs 0..INTERVAL-1 and wraps.
  - The tick is asserted when the counter equals INTERVAL-1.
  - IDLE leaves on the tick. A tick in any other state is ignored. No queuing.
- FSM, one state per cycle, no waits:
  - IDLE -> RD_CTL: EN=1, WE=0, ADDR=ADDR_CTL_REG.
  - RD_CTL -> RD_WAIT: EN=0.
  - RD_WAIT -> RD_LATCH: force_fan <= BRAM_DOUT[CTL_FORCE_FAN_BIT].
  - RD_LATCH -> WR_INFO: EN=1, WE=1, ADDR=ADDR_FPGA_INFO, DIN={14'b0, thermo_q|force_fan, thermo_q}.
  - WR_INFO -> WR_SYNC: EN=1, WE=1, ADDR=ADDR_SYNC_CNT, DIN=sync_cnt.
  - WR_SYNC -> WR_VER: EN=1, WE=1, ADDR=ADDR_VERSION, DIN=VERSION.
  - WR_VER -> IDLE: EN=0, WE=0, SEQ_DONE=1 for exactly this cycle.
- Timing:
  - The first write occurs 4 cycles after the tick.
  - SEQ_DONE rises 7 cycles after the tick.
  - BRAM_ADDR and BRAM_DIN hold their last values while EN=0.
- sync_cnt:
  - 16-bit; increments on every cycle with SYNC_SET=1.
  - Wraps 0xFFFF -> 0x0000.
  - Counting continues in every state.
  - The value written is the register value at the start of the WR_SYNC cycle. A pulse in that same cycle appears in the next sequence.
- thermo_q: equals THERMO registered by one cycle (without the optional feature).
- FAN_ACTIVE:
  - registered thermo_q|force_fan, updated every cycle;
  - force_fan changes only in RD_LATCH.
- Reset mid-sequence:
  - all outputs return to reset values immediately;
  - the partially written sequence is abandoned;
  - the next sequence starts after a full INTERVAL.
- The port is owned by this block while EN=1. Arbitration with controller reads lives outside this block.

Optional Feature:
- Macro THERMO_DEBOUNCE_EN defined:
  - thermo_q changes only after THERMO has held a new level for DEBOUNCE consecutive cycles;
  - the debounce counter clears on any mismatch;
  - reset value of thermo_q is 0.
- Macro undefined: thermo_q is THERMO delayed by 1 cycle.

Decomposition:
- Package ctl_status_pkg holds:
  - the state enum (IDLE, RD_CTL, RD_WAIT, RD_LATCH, WR_INFO, WR_SYNC, WR_VER);
  - ADDR_CTL_REG=9'h000, ADDR_FPGA_INFO=9'h001, ADDR_SYNC_CNT=9'h002, ADDR_VERSION=9'h03F;
  - CTL_FORCE_FAN_BIT=4.
- controller imports the same address constants.
- One sub-module: thermo_debounce. It is instantiated only under THERMO_DEBOUNCE_EN; otherwise a single flop is used.

Test Plan:
- Reset: assert RST for 5 cycles mid-run -> all outputs 0 and sync_cnt 0. After release, the first BRAM_EN occurs exactly INTERVAL cycles later.
- INTERVAL=16, THERMO=1, ctl reg 0x0000 -> writes seen in order at cycles tick+4/5/6: 0x001<=0x0003, 0x002<=0x0000, 0x03F<=0x0082. SEQ_DONE at tick+7.
- THERMO=0, ctl reg 0x0010 -> 0x001<=0x0002; FAN_ACTIVE=1 from the cycle after RD_LATCH.
- Sync counter:
  - 3 SYNC_SET pulses before a tick -> 0x002<=0x0003.
  - Preload 0xFFFF pulses, then 1 more pulse -> next write 0x0000.
  - A pulse during WR_SYNC is counted in the next sequence.
- RST asserted during WR_INFO -> WR_SYNC and WR_VER never occur; EN=0 immediately.
- THERMO_DEBOUNCE_EN, DEBOUNCE=16:
  - a 10-cycle THERMO glitch -> info bit0 stays 0;
  - a 20-cycle high -> bit0=1 in the next sequence.
